// File: rtl/mont_pkg.sv
// ----------------------------------------------------------------------------
// mont_pkg
// Shared definitions for the Montgomery candidate-selection datapath.
//   calc_ncand / calc_cw / calc_idxw : derive NCAND, CW and IDXW from the
//                                      lane count and data width
//   idx_accum                        : index sentinel meaning "the accumulator
//                                      was selected" (value NCAND)
//   cand_sign                        : sign bit of a CW-wide candidate
// ----------------------------------------------------------------------------
package mont_pkg;

    localparam int STAT_W = 32;

    // One candidate per pair of lanes plus the unsubtracted value.
    function automatic int calc_ncand(input int mlsize);
        return mlsize / 2 + 1;
    endfunction

    // Reduced value plus lane-growth bits, one guard bit and the sign bit.
    function automatic int calc_cw(input int nbits, input int pbits);
        return nbits + pbits + 2;
    endfunction

    // Must also encode the sentinel value NCAND.
    function automatic int calc_idxw(input int ncand);
        return $clog2(ncand + 1);
    endfunction

    function automatic int idx_accum(input int ncand);
        return ncand;
    endfunction

    // Candidates are zero-extended into 64 bits; the sign sits at cw-1.
    function automatic logic cand_sign(input logic [63:0] value, input int cw);
        logic [5:0] pos;
        pos = 6'(cw - 1);
        return value[pos];
    endfunction

endpackage

// File: rtl/mont_prio_pick.sv
// ----------------------------------------------------------------------------
// mont_prio_pick
// Combinational priority picker over a W-bit request vector.
//   vec    in  W   request bits
//   onehot out W   the single winning bit (all zero when none)
//   idx    out IW  binary position of the winner (0 when none)
//   none   out 1   no request bit set
// PRIO_HIGH=1 makes the highest set position win, PRIO_HIGH=0 the lowest.
// ----------------------------------------------------------------------------
module mont_prio_pick #(
    parameter int W         = 1,
    parameter int PRIO_HIGH = 1,
    parameter int IW        = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [W-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          none
);

    // Scan in the direction that lets the winning bit be the last one seen.
    always_comb begin
        onehot = '0;
        idx    = '0;
        none   = 1'b1;
        if (PRIO_HIGH != 0) begin
            for (int i = 0; i < W; i++) begin
                if (vec[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = IW'(i);
                    none      = 1'b0;
                end
            end
        end else begin
            for (int i = W - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                    idx       = IW'(i);
                    none      = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mont_cand_select_pipe.sv
// ----------------------------------------------------------------------------
// mont_cand_select_pipe
// Two-stage pipelined selector for radix-2^PBITS Montgomery reduction. Each
// transaction carries NCAND signed trial-subtraction candidates; the block
// returns the priority-winning non-negative candidate inside a window of
// NCAND-1 entries, or a fallback value when none is non-negative.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_cand       NCAND*CW packed candidates, candidate k at [k*CW +: CW]
//   in_accum      fallback value when in_bypass=1
//   in_bypass     1: window 0..NCAND-2, fallback in_accum
//                 0: window 1..NCAND-1, fallback cand[0][NBITS-1:0]
//   out_valid/out_ready output handshake
//   out_data      selected value
//   out_idx       selected candidate index (NCAND = accumulator)
//   out_fallback  no window candidate was non-negative
//
// Optional (macro MONT_SEL_STATS_EN):
//   stat_fallback_cnt  saturating count of fallback results transferred out
//   stat_stall         out_valid && !out_ready
//
// Handshake: a beat moves on a rising edge where valid && ready. A producer
// holds valid and payload stable until it moves; out_data/out_idx/
// out_fallback stay stable while out_valid && !out_ready. in_ready is
// combinational and only drops when both stages are full and the output is
// stalled.
// ----------------------------------------------------------------------------
module mont_cand_select_pipe
    import mont_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int PBITS     = 1,
    parameter int MLSIZE    = 1 << PBITS,
    parameter int NCAND     = calc_ncand(MLSIZE),
    parameter int CW        = calc_cw(NBITS, PBITS),
    parameter int IDXW      = calc_idxw(NCAND),
    parameter int PRIO_HIGH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCAND*CW-1:0]   in_cand,
    input  logic [NBITS-1:0]      in_accum,
    input  logic                  in_bypass,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NBITS-1:0]      out_data,
    output logic [IDXW-1:0]       out_idx,
    output logic                  out_fallback
`ifdef MONT_SEL_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_fallback_cnt,
    output logic                  stat_stall
`endif
);

    localparam int WIN = NCAND - 1;
    localparam int PW  = (WIN > 1) ? $clog2(WIN) : 1;

    // ---------------- stage A ----------------
    logic               a_valid;
    logic [WIN-1:0]     a_nn;
    logic [NBITS-1:0]   a_data [NCAND];
    logic [NBITS-1:0]   a_fb;
    logic               a_bypass;

    logic [WIN-1:0]     nn_win;
    logic [NBITS-1:0]   cand_lo [NCAND];
    logic [NBITS-1:0]   fb_in;
    logic               in_xfer;
    logic               b_en;

    // Stage B can take a new beat whenever the output register is free or
    // being drained this cycle.
    assign b_en     = !out_valid || out_ready;
    assign in_ready = !a_valid || b_en;
    assign in_xfer  = in_valid && in_ready;

    // Window entry j maps to candidate j (bypass) or j+1 (no bypass). Guard
    // bits between NBITS and the sign are dropped here.
    always_comb begin
        nn_win = '0;
        for (int k = 0; k < NCAND; k++) begin
            cand_lo[k] = in_cand[k*CW +: NBITS];
        end
        for (int j = 0; j < WIN; j++) begin
            if (in_bypass) begin
                nn_win[j] = !cand_sign(64'(in_cand[j*CW +: CW]), CW);
            end else begin
                nn_win[j] = !cand_sign(64'(in_cand[(j+1)*CW +: CW]), CW);
            end
        end
        fb_in = in_bypass ? in_accum : in_cand[NBITS-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid  <= 1'b0;
            a_nn     <= '0;
            a_fb     <= '0;
            a_bypass <= 1'b0;
            for (int k = 0; k < NCAND; k++) begin
                a_data[k] <= '0;
            end
        end else if (in_xfer) begin
            a_valid  <= 1'b1;
            a_nn     <= nn_win;
            a_data   <= cand_lo;
            a_fb     <= fb_in;
            a_bypass <= in_bypass;
        end else if (b_en) begin
            a_valid  <= 1'b0;
        end
    end

    // ---------------- stage B ----------------
    logic [WIN-1:0]   pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_none;
    logic [NBITS-1:0] b_data;
    logic [IDXW-1:0]  b_idx;

    mont_prio_pick #(
        .W         (WIN),
        .PRIO_HIGH (PRIO_HIGH),
        .IW        (PW)
    ) u_pick (
        .vec    (a_nn),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .none   (pick_none)
    );

    // The picker works in window positions; shift back to the real
    // candidate index when the window starts at candidate 1.
    always_comb begin
        b_data = '0;
        b_idx  = a_bypass ? IDXW'(pick_idx) : IDXW'(pick_idx) + IDXW'(1);
        for (int j = 0; j < WIN; j++) begin
            if (pick_oh[j]) begin
                b_data = a_bypass ? a_data[j] : a_data[j+1];
            end
        end
        if (pick_none) begin
            b_data = a_fb;
            b_idx  = a_bypass ? IDXW'(idx_accum(NCAND)) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_fallback <= 1'b0;
        end else if (b_en) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_data     <= b_data;
                out_idx      <= b_idx;
                out_fallback <= pick_none;
            end
        end
    end

`ifdef MONT_SEL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fallback_cnt <= '0;
        end else if (out_valid && out_ready && out_fallback &&
                     (stat_fallback_cnt != {STAT_W{1'b1}})) begin
            stat_fallback_cnt <= stat_fallback_cnt + 1'b1;
        end
    end

    assign stat_stall = out_valid && !out_ready;
`endif

endmodule

// File: tb/tb_mont_cand_select_pipe.sv
// ----------------------------------------------------------------------------
// tb_mont_cand_select_pipe
// Drives two selector instances (PRIO_HIGH=1 and PRIO_HIGH=0) from the same
// stimulus with NBITS=8, PBITS=2 (NCAND=3, CW=12, IDXW=2). A queue-level
// model predicts readiness, output validity and the selected result; a
// compare process checks every cycle, and literal cases pin the model.
// ----------------------------------------------------------------------------
module tb_mont_cand_select_pipe;

    localparam int NBITS = 8;
    localparam int PBITS = 2;
    localparam int NCAND = 3;
    localparam int CW    = 12;
    localparam int IDXW  = 2;
    localparam int RW    = NBITS + IDXW + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                in_valid;
    logic [NCAND*CW-1:0] in_cand;
    logic [NBITS-1:0]    in_accum;
    logic                in_bypass;
    logic                out_ready;

    logic                in_ready_h, out_valid_h, out_fallback_h;
    logic [NBITS-1:0]    out_data_h;
    logic [IDXW-1:0]     out_idx_h;
    logic                in_ready_l, out_valid_l, out_fallback_l;
    logic [NBITS-1:0]    out_data_l;
    logic [IDXW-1:0]     out_idx_l;

    mont_cand_select_pipe #(.NBITS(NBITS), .PBITS(PBITS), .PRIO_HIGH(1)) dut_h (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_h),
        .in_cand(in_cand), .in_accum(in_accum), .in_bypass(in_bypass),
        .out_valid(out_valid_h), .out_ready(out_ready),
        .out_data(out_data_h), .out_idx(out_idx_h), .out_fallback(out_fallback_h)
    );

    mont_cand_select_pipe #(.NBITS(NBITS), .PBITS(PBITS), .PRIO_HIGH(0)) dut_l (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_l),
        .in_cand(in_cand), .in_accum(in_accum), .in_bypass(in_bypass),
        .out_valid(out_valid_l), .out_ready(out_ready),
        .out_data(out_data_l), .out_idx(out_idx_l), .out_fallback(out_fallback_l)
    );

    // ---------------- check bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference selection ----------------
    // Result packed as {data, idx, fallback}.
    function automatic logic [RW-1:0] ref_sel(input logic [NCAND*CW-1:0] c,
                                              input logic [NBITS-1:0] acc,
                                              input logic byp, input bit prio_high);
        int lo, hi, win;
        logic [CW-1:0]    v;
        logic [NBITS-1:0] d;
        lo  = byp ? 0 : 1;
        hi  = lo + NCAND - 2;
        win = -1;
        for (int k = lo; k <= hi; k++) begin
            v = c[k*CW +: CW];
            if (!v[CW-1] && (prio_high || win < 0)) win = k;
        end
        if (win < 0) begin
            d = byp ? acc : c[NBITS-1:0];
            return {d, (byp ? IDXW'(NCAND) : IDXW'(0)), 1'b1};
        end
        d = c[win*CW +: NBITS];
        return {d, IDXW'(win), 1'b0};
    endfunction

    // ---------------- behavioural model ----------------
    // At most two beats in flight; the oldest is visible once it has
    // survived one edge without being drained.
    logic [RW-1:0] exp_q_h[$];
    logic [RW-1:0] exp_q_l[$];
    int m_n        = 0;
    bit m_head     = 1'b0;
    bit m_acc      = 1'b0;
    int m_accepted = 0;
    int m_drained  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_h.delete();
            exp_q_l.delete();
            m_n    = 0;
            m_head = 1'b0;
            m_acc  = 1'b0;
        end else begin : model_step
            bit acc, drn;
            int left;
            acc = in_valid && (m_n < 2 || out_ready);
            drn = m_head && out_ready;
            if (drn) begin
                void'(exp_q_h.pop_front());
                void'(exp_q_l.pop_front());
                m_drained++;
            end
            left = m_n - int'(drn);
            if (acc) begin
                exp_q_h.push_back(ref_sel(in_cand, in_accum, in_bypass, 1'b1));
                exp_q_l.push_back(ref_sel(in_cand, in_accum, in_bypass, 1'b0));
                m_accepted++;
            end
            m_head = (left > 0);
            m_n    = left + int'(acc);
            m_acc  = acc;
        end
    end

    // ---------------- scoreboard compare ----------------
    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        if (rst_n && run_cmp) begin : cmp
            logic exp_rdy;
            exp_rdy = (m_n < 2) || out_ready;
            check("in_ready_h", 32'(in_ready_h), 32'(exp_rdy));
            check("in_ready_l", 32'(in_ready_l), 32'(exp_rdy));
            check("out_valid_h", 32'(out_valid_h), 32'(m_head));
            check("out_valid_l", 32'(out_valid_l), 32'(m_head));
            if (m_head && exp_q_h.size() > 0) begin
                check("result_h", 32'({out_data_h, out_idx_h, out_fallback_h}), 32'(exp_q_h[0]));
                check("result_l", 32'({out_data_l, out_idx_l, out_fallback_l}), 32'(exp_q_l[0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_item(input logic [NCAND*CW-1:0] c, input logic [NBITS-1:0] acc,
                            input logic byp);
        in_cand   = c;
        in_accum  = acc;
        in_bypass = byp;
    endtask

    task automatic send(input logic [NCAND*CW-1:0] c, input logic [NBITS-1:0] acc,
                        input logic byp);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        #1;
        set_item(c, acc, byp);
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (m_acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic expect_lit(string nm, input logic [RW-1:0] eh, input logic [RW-1:0] el);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (out_valid_h) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
        else begin
            check({nm, "_h"}, 32'({out_data_h, out_idx_h, out_fallback_h}), 32'(eh));
            check({nm, "_l"}, 32'({out_data_l, out_idx_l, out_fallback_l}), 32'(el));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    logic [NCAND*CW-1:0] stall_c [4];
    int acc_base, dr_base, sent;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_item('0, '0, 1'b0);

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid_h), 32'd0);
        check("rst_out_data", 32'(out_data_h), 32'd0);
        check("rst_out_idx", 32'(out_idx_h), 32'd0);
        check("rst_out_fallback", 32'(out_fallback_h), 32'd0);
        check("rst_in_ready", 32'(in_ready_h), 32'd1);
        #1;
        rst_n   = 1'b1;
        run_cmp = 1'b1;

        // Model pins.
        check("model_t1", 32'(ref_sel({12'h056, 12'h834, 12'h012}, 8'h00, 1'b0, 1'b1)),
              32'({8'h56, 2'd2, 1'b0}));
        check("model_t4_low", 32'(ref_sel({12'h007, 12'h005, 12'h099}, 8'h00, 1'b0, 1'b0)),
              32'({8'h05, 2'd1, 1'b0}));
        check("model_accum", 32'(ref_sel({12'h000, 12'h8EE, 12'h8FF}, 8'hAA, 1'b1, 1'b1)),
              32'({8'hAA, 2'd3, 1'b1}));

        // Directed literal cases.
        send({12'h056, 12'h834, 12'h012}, 8'h00, 1'b0);
        expect_lit("t1", {8'h56, 2'd2, 1'b0}, {8'h56, 2'd2, 1'b0});
        send({12'h033, 12'h822, 12'h011}, 8'hAA, 1'b1);
        expect_lit("t2", {8'h11, 2'd0, 1'b0}, {8'h11, 2'd0, 1'b0});
        send({12'h000, 12'h8EE, 12'h8FF}, 8'hAA, 1'b1);
        expect_lit("t3_accum", {8'hAA, 2'd3, 1'b1}, {8'hAA, 2'd3, 1'b1});
        send({12'h8EE, 12'h8FF, 12'h044}, 8'hAA, 1'b0);
        expect_lit("t3_cand0", {8'h44, 2'd0, 1'b1}, {8'h44, 2'd0, 1'b1});
        send({12'h007, 12'h005, 12'h099}, 8'h00, 1'b0);
        expect_lit("t4", {8'h07, 2'd2, 1'b0}, {8'h05, 2'd1, 1'b0});
        repeat (3) @(negedge clk);

        // Backpressure: 6 stalled cycles with 4 beats offered.
        for (int i = 0; i < 4; i++) begin
            stall_c[i] = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                          12'($urandom_range(0, 4095))};
        end
        acc_base = m_accepted;
        dr_base  = m_drained;
        sent     = 0;
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        set_item(stall_c[0], 8'h3C, 1'b0);
        in_valid = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (m_acc) begin
                sent++;
                if (sent < 4) set_item(stall_c[sent], 8'h3C, 1'b0);
                else in_valid = 1'b0;
            end
        end
        check("stall_accepted", 32'(m_accepted - acc_base), 32'd2);
        check("stall_in_ready", 32'(in_ready_h), 32'd0);
        @(negedge clk);
        #1;
        out_ready = 1'b1;
        for (int t = 0; t < 30 && (m_drained - dr_base) < 4; t++) begin
            @(posedge clk);
            #1;
            if (m_acc) begin
                sent++;
                if (sent < 4) set_item(stall_c[sent], 8'h3C, 1'b0);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("stall_drained", 32'(m_drained - dr_base), 32'd4);

        // Reset with two beats in flight.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        send({12'h001, 12'h002, 12'h003}, 8'h11, 1'b0);
        send({12'h004, 12'h005, 12'h006}, 8'h22, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid_h", 32'(out_valid_h), 32'd0);
        check("rst_async_valid_l", 32'(out_valid_l), 32'd0);
        check("rst_async_in_ready", 32'(in_ready_h), 32'd1);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_stale", 32'(out_valid_h), 32'd0);

        // Randomized traffic with random backpressure.
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            #1;
            if (!in_valid || m_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                set_item({12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                          12'($urandom_range(0, 4095))},
                         8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("final_empty", 32'(out_valid_h), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
